// File: rtl/lpor_lock_pkg.sv
// Shared widths, key-loader state encoding and operand pair type for the
// key-locked lower-part-OR adder input stage.
package lpor_lock_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned KEY_W  = 32;
  localparam int unsigned CNT_W  = $clog2(KEY_W + 1);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(KEY_W);

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    LOADING = 2'd1,
    FULL    = 2'd2,
    ARMED   = 2'd3
  } key_state_e;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } operand_pair_t;

endpackage

// File: rtl/lpor_key_shift_reg.sv
// Serial key loader: MSB-first shift register, saturating bit counter,
// seal FSM and sticky misuse flag. The key leaves only once sealed.
module lpor_key_shift_reg
  import lpor_lock_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_sdi,
  input  logic             key_shift,
  input  logic             key_commit,
  output logic             armed_o,
  output logic             err_o,
  output logic [KEY_W-1:0] key_o
);

  key_state_e       state_q, state_d;
  logic [KEY_W-1:0] sr_q, sr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [KEY_W-1:0] key_q, key_d;

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      EMPTY, LOADING: begin
        if (key_commit) err_d = 1'b1;
        if (key_shift) begin
          sr_d    = {sr_q[KEY_W-2:0], key_sdi};
          cnt_d   = (cnt_q == CNT_FULL) ? cnt_q : cnt_q + 1'b1;
          state_d = (cnt_d == CNT_FULL) ? FULL : LOADING;
        end
      end
      FULL: begin
        // Commit beats a simultaneous shift so the sealed key is the one observed.
        if (key_commit) state_d = ARMED;
        else if (key_shift) sr_d = {sr_q[KEY_W-2:0], key_sdi};
      end
      ARMED: begin
        if (key_shift || key_commit) err_d = 1'b1;
      end
      default: state_d = EMPTY;
    endcase
    key_d = (state_d == ARMED) ? sr_d : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      sr_q    <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      key_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      key_q   <= key_d;
    end
  end

  assign armed_o = (state_q == ARMED);
  assign err_o   = err_q;
  assign key_o   = key_q;

endmodule

// File: rtl/lpor_adder_key_operand_stager.sv
// Input stage of the key-locked LOA adder: key loader plus a one-entry
// valid/ready operand register that only opens once the key is sealed.
module lpor_adder_key_operand_stager
  import lpor_lock_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              key_sdi,
  input  logic              key_shift,
  input  logic              key_commit,
  output logic              key_armed_o,
  output logic              key_err_o,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] add1_o,
  output logic [DATA_W-1:0] add2_o,
  output logic [KEY_W-1:0]  keyinput_o
);

  operand_pair_t pair_q, pair_d;
  logic          valid_q, valid_d;
  logic          accept;

  lpor_key_shift_reg u_key (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_sdi    (key_sdi),
    .key_shift  (key_shift),
    .key_commit (key_commit),
    .armed_o    (key_armed_o),
    .err_o      (key_err_o),
    .key_o      (keyinput_o)
  );

  assign in_ready = key_armed_o & (~valid_q | out_ready);
  assign accept   = in_valid & in_ready;

  always_comb begin
    pair_d  = pair_q;
    valid_d = valid_q;
    if (accept) begin
      pair_d.a = in_a;
      pair_d.b = in_b;
      valid_d  = 1'b1;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pair_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      pair_q  <= pair_d;
      valid_q <= valid_d;
    end
  end

  assign out_valid = valid_q;
  assign add1_o    = pair_q.a;
  assign add2_o    = pair_q.b;

endmodule

// File: tb/tb_lpor_adder_key_operand_stager.sv
// Directed bench for the LOA key/operand stager with immediate-assertion checks.
module tb_lpor_adder_key_operand_stager;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        key_sdi, key_shift, key_commit;
  logic        key_armed_o, key_err_o;
  logic        in_valid, in_ready;
  logic [15:0] in_a, in_b;
  logic        out_valid, out_ready;
  logic [15:0] add1_o, add2_o;
  logic [31:0] keyinput_o;

  int total = 0;
  int bad   = 0;

  logic [31:0] k1 = 32'hA5C3_0F96;
  logic [31:0] k2 = 32'h5A3C_F069;

  always #5 clk = ~clk;

  lpor_adder_key_operand_stager dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_sdi    (key_sdi),
    .key_shift  (key_shift),
    .key_commit (key_commit),
    .key_armed_o(key_armed_o),
    .key_err_o  (key_err_o),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .add1_o     (add1_o),
    .add2_o     (add2_o),
    .keyinput_o (keyinput_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".armed"}, {31'd0, key_armed_o}, 32'd0);
    chk({tag, ".err"},   {31'd0, key_err_o},   32'd0);
    chk({tag, ".rdy"},   {31'd0, in_ready},    32'd0);
    chk({tag, ".ov"},    {31'd0, out_valid},   32'd0);
    chk({tag, ".a1"},    {16'd0, add1_o},      32'd0);
    chk({tag, ".a2"},    {16'd0, add2_o},      32'd0);
    chk({tag, ".key"},   keyinput_o,           32'd0);
  endtask

  // Shift bits [hi:lo] of k MSB first, checking the key stays hidden.
  task automatic shift_bits(input logic [31:0] k, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) begin
      key_sdi   = k[i];
      key_shift = 1'b1;
      tick();
      chk("load.key_hidden", keyinput_o, 32'd0);
    end
    key_shift = 1'b0;
    key_sdi   = 1'b0;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #2;
    chk_all_zero("rst");
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; key_sdi = 0; key_shift = 0; key_commit = 0;
    in_valid = 0; in_a = '0; in_b = '0; out_ready = 0;
    #12;
    chk_all_zero("por");
    rst_n = 1'b1;

    // Test 1: full load and commit
    shift_bits(k1, 31, 0);
    chk("t1.pre_armed", {31'd0, key_armed_o}, 32'd0);
    in_valid = 1'b1; out_ready = 1'b1; #1;
    chk("t1.rdy_unarmed", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b0;
    key_commit = 1'b1;
    tick();
    key_commit = 1'b0;
    chk("t1.armed", {31'd0, key_armed_o}, 32'd1);
    chk("t1.key",   keyinput_o, 32'hA5C3_0F96);
    chk("t1.err",   {31'd0, key_err_o}, 32'd0);
    chk("t1.ov",    {31'd0, out_valid}, 32'd0);

    // Test 3: single operand pair
    in_valid = 1'b1; in_a = 16'h1234; in_b = 16'h00FF; out_ready = 1'b1; #1;
    chk("t3.rdy", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    chk("t3.a1", {16'd0, add1_o}, 32'h1234);
    chk("t3.a2", {16'd0, add2_o}, 32'h00FF);
    chk("t3.ov", {31'd0, out_valid}, 32'd1);
    tick();
    chk("t3.drain_ov", {31'd0, out_valid}, 32'd0);
    chk("t3.hold_a1",  {16'd0, add1_o}, 32'h1234);

    // Test 4: backpressure then full throughput
    out_ready = 1'b0; in_valid = 1'b1; in_a = 16'h1111; in_b = 16'h2222;
    tick();
    in_a = 16'h3333; in_b = 16'h4444;
    for (int c = 0; c < 5; c++) begin
      chk("t4.rdy_low", {31'd0, in_ready}, 32'd0);
      tick();
      chk("t4.ov_hold", {31'd0, out_valid}, 32'd1);
      chk("t4.a1_hold", {16'd0, add1_o}, 32'h1111);
      chk("t4.a2_hold", {16'd0, add2_o}, 32'h2222);
    end
    out_ready = 1'b1; #1;
    chk("t4.rdy_release", {31'd0, in_ready}, 32'd1);
    tick();
    chk("t4.p1", {add1_o, add2_o}, 32'h3333_4444);
    in_a = 16'h5555; in_b = 16'h6666;
    tick();
    chk("t4.p2", {add1_o, add2_o}, 32'h5555_6666);
    chk("t4.p2ov", {31'd0, out_valid}, 32'd1);
    in_a = 16'h7777; in_b = 16'h8888;
    tick();
    chk("t4.p3", {add1_o, add2_o}, 32'h7777_8888);
    in_valid = 1'b0;
    tick();
    chk("t4.empty", {31'd0, out_valid}, 32'd0);

    // Test 5: shifts after seal
    key_sdi = 1'b1; key_shift = 1'b1;
    repeat (8) tick();
    key_shift = 1'b0; key_sdi = 1'b0;
    chk("t5.key",   keyinput_o, 32'hA5C3_0F96);
    chk("t5.err",   {31'd0, key_err_o}, 32'd1);
    chk("t5.armed", {31'd0, key_armed_o}, 32'd1);

    // Test 6a: reset mid-load, then Test 2: premature commit
    pulse_reset();
    shift_bits(k2, 31, 15);
    pulse_reset();
    shift_bits(k2, 31, 1);
    key_commit = 1'b1;
    tick();
    key_commit = 1'b0;
    chk("t2.armed_no", {31'd0, key_armed_o}, 32'd0);
    chk("t2.err",      {31'd0, key_err_o}, 32'd1);
    chk("t2.key0",     keyinput_o, 32'd0);
    shift_bits(k2, 0, 0);
    key_commit = 1'b1;
    tick();
    key_commit = 1'b0;
    chk("t2.armed", {31'd0, key_armed_o}, 32'd1);
    chk("t2.key",   keyinput_o, 32'h5A3C_F069);
    chk("t2.err_sticky", {31'd0, key_err_o}, 32'd1);

    // Test 6b: reset while a pair is held
    in_valid = 1'b1; in_a = 16'hBEEF; in_b = 16'hCAFE; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    chk("t6.ov", {31'd0, out_valid}, 32'd1);
    pulse_reset();

    // Over-shift in FULL drops the oldest bit; commit beats a same-cycle shift
    key_sdi = 1'b1; key_shift = 1'b1;
    tick();
    key_shift = 1'b0;
    shift_bits(k1, 31, 0);
    key_sdi = 1'b1; key_shift = 1'b1; key_commit = 1'b1;
    tick();
    key_shift = 1'b0; key_commit = 1'b0; key_sdi = 1'b0;
    chk("full.armed", {31'd0, key_armed_o}, 32'd1);
    chk("full.key",   keyinput_o, 32'hA5C3_0F96);
    chk("full.err",   {31'd0, key_err_o}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

endmodule
